// File: rtl/pid_gain_sequencer.sv
// pid_gain_sequencer: holds the PID controller in reset, streams
// the Kp/Ki/Kd gain codes on its setpoint bus, then hands over.
module pid_gain_sequencer #(
    parameter int          RST_CYCLES    = 2,
    parameter logic [11:0] DEFAULT_GAINS = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [11:0] cfg_data,
    input  logic [7:0]  user_setpoint,
    output logic        pid_rst_n,
    output logic [7:0]  pid_setpoint,
    output logic        busy,
    output logic        fetch_done
);

    typedef enum logic [2:0] {
        HOLD,
        KP,
        KI,
        KD,
        RUN
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(RST_CYCLES - 1);

    state_t      state;
    state_t      state_nx;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nx;
    logic [3:0]  kp;
    logic [3:0]  ki;
    logic [3:0]  kd;
    logic        wr_acc;
    logic        rst_n_nx;
    logic [7:0]  sp_nx;
    logic        busy_nx;
    logic        done_nx;

    // Ready depends only on the state flop.
    assign cfg_ready = (state == RUN);
    assign wr_acc    = cfg_valid && cfg_ready;

    // Gain registers: defaults on reset, replaced by an accepted write.
    always_ff @(posedge clk) begin
        if (rst) begin
            kp <= DEFAULT_GAINS[3:0];
            ki <= DEFAULT_GAINS[7:4];
            kd <= DEFAULT_GAINS[11:8];
        end else if (wr_acc) begin
            kp <= cfg_data[3:0];
            ki <= cfg_data[7:4];
            kd <= cfg_data[11:8];
        end
    end

    // Next state and next (registered) output values.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        rst_n_nx = 1'b1;
        sp_nx    = 8'h00;
        busy_nx  = 1'b1;
        done_nx  = 1'b0;

        unique case (state)
            HOLD: begin
                if (cnt == CNT_LAST) begin
                    state_nx = KP;
                    cnt_nx   = 4'd0;
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            KP:  state_nx = KI;
            KI:  state_nx = KD;
            KD:  state_nx = RUN;
            RUN: begin
                if (wr_acc) begin
                    state_nx = HOLD;
                    cnt_nx   = 4'd0;
                end
            end
            default: begin
                state_nx = HOLD;
                cnt_nx   = 4'd0;
            end
        endcase

        unique case (state_nx)
            HOLD: rst_n_nx = 1'b0;
            KP:   sp_nx    = {4'h0, kp};
            KI:   sp_nx    = {4'h0, ki};
            KD:   sp_nx    = {4'h0, kd};
            RUN: begin
                sp_nx   = user_setpoint;
                busy_nx = 1'b0;
                done_nx = (state == KD);
            end
            default: rst_n_nx = 1'b0;
        endcase
    end

    // State, counter and output flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= HOLD;
            cnt          <= 4'd0;
            pid_rst_n    <= 1'b0;
            pid_setpoint <= 8'h00;
            busy         <= 1'b1;
            fetch_done   <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            pid_rst_n    <= rst_n_nx;
            pid_setpoint <= sp_nx;
            busy         <= busy_nx;
            fetch_done   <= done_nx;
        end
    end

endmodule

// File: tb/tb_pid_gain_sequencer.sv
// tb_pid_gain_sequencer: two instances (RST_CYCLES 2 and 1) driven
// with directed and random traffic against a timeline model.
module tb_pid_gain_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       = 1'b1;
    logic        cfg_valid = 1'b0;
    logic [11:0] cfg_data  = 12'h000;
    logic [7:0]  us        = 8'h00;

    logic        rdy [2];
    logic        prn [2];
    logic        bsy [2];
    logic        done[2];
    logic [7:0]  sp  [2];

    localparam logic [11:0] DEFG[2] = '{12'h5A3, 12'hC7E};
    localparam int          RC  [2] = '{2, 1};

    pid_gain_sequencer #(
        .RST_CYCLES   (2),
        .DEFAULT_GAINS(12'h5A3)
    ) u0 (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (rdy[0]),
        .cfg_data     (cfg_data),
        .user_setpoint(us),
        .pid_rst_n    (prn[0]),
        .pid_setpoint (sp[0]),
        .busy         (bsy[0]),
        .fetch_done   (done[0])
    );

    pid_gain_sequencer #(
        .RST_CYCLES   (1),
        .DEFAULT_GAINS(12'hC7E)
    ) u1 (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (rdy[1]),
        .cfg_data     (cfg_data),
        .user_setpoint(us),
        .pid_rst_n    (prn[1]),
        .pid_setpoint (sp[1]),
        .busy         (bsy[1]),
        .fetch_done   (done[1])
    );

    int          checks = 0;
    int          errors = 0;
    // t: cycles since the current sequence began (0 = first HOLD)
    int          t    [2] = '{0, 0};
    logic [11:0] g    [2] = '{12'h000, 12'h000};
    logic [7:0]  pus  [2] = '{8'h00, 8'h00};
    logic [3:0]  cap  [2][3];
    int          cidx [2] = '{0, 0};
    bit          acc0 = 1'b0;
    int          acc_t0 = -1;

    task automatic chk(input string tag, input int i,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0h want %0h @%0t",
                     tag, i, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_sp(input int i);
        int r;
        r = RC[i];
        if (t[i] < r)      return 8'h00;
        if (t[i] == r)     return {4'h0, g[i][3:0]};
        if (t[i] == r + 1) return {4'h0, g[i][7:4]};
        if (t[i] == r + 2) return {4'h0, g[i][11:8]};
        return pus[i];
    endfunction

    // One clock: advance the model at the edge, compare mid-cycle.
    task automatic step();
        @(posedge clk);
        acc0 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                t[i] = 0;
                g[i] = DEFG[i];
            end else if (t[i] >= RC[i] + 3 && cfg_valid) begin
                if (i == 0) begin
                    acc0   = 1'b1;
                    acc_t0 = t[i];
                end
                g[i] = cfg_data;
                t[i] = 0;
            end else if (t[i] < 60) begin
                t[i] = t[i] + 1;
            end
            pus[i] = us;
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("pid_rst_n", i, 32'(prn[i]), 32'(t[i] >= RC[i]));
            chk("setpoint", i, 32'(sp[i]), 32'(exp_sp(i)));
            chk("busy", i, 32'(bsy[i]), 32'(t[i] < RC[i] + 3));
            chk("fetch_done", i, 32'(done[i]),
                32'(t[i] == RC[i] + 3));
            chk("cfg_ready", i, 32'(rdy[i]), 32'(t[i] >= RC[i] + 3));
            if (t[i] == RC[i] + 3) begin
                chk("ctl_kp", i, 32'(cap[i][0]), 32'(g[i][3:0]));
                chk("ctl_ki", i, 32'(cap[i][1]), 32'(g[i][7:4]));
                chk("ctl_kd", i, 32'(cap[i][2]), 32'(g[i][11:8]));
            end
            // Controller stand-in: latches three codes after reset.
            if (!prn[i]) begin
                cidx[i] = 0;
            end else if (cidx[i] < 3) begin
                cap[i][cidx[i]] = sp[i][3:0];
                cidx[i] = cidx[i] + 1;
            end
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 3; k++)
                cap[i][k] = 4'h0;

        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        us  = 8'h40;
        repeat (8) step();
        us = 8'h80;
        repeat (4) step();

        cfg_data  = 12'hF0B;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        repeat (10) step();

        // Start a sequence, then raise valid while it is in KI.
        cfg_data  = 12'h3C1;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        n = 0;
        while (t[0] != RC[0] + 1 && n < 20) begin
            step();
            n++;
        end
        chk("reach_ki", 0, 32'(t[0]), 32'(RC[0] + 1));
        cfg_data  = 12'h96D;
        cfg_valid = 1'b1;
        n = 0;
        acc0 = 1'b0;
        while (!acc0 && n < 20) begin
            step();
            n++;
        end
        chk("acc_seen", 0, 32'(acc0), 32'd1);
        chk("acc_first_run", 0, 32'(acc_t0), 32'(RC[0] + 3));
        cfg_valid = 1'b0;
        repeat (12) step();

        // Reset while a write is pending during KI.
        cfg_data  = 12'h123;
        cfg_valid = 1'b1;
        step();
        n = 0;
        while (t[0] != RC[0] + 1 && n < 20) begin
            step();
            n++;
        end
        chk("reach_ki2", 0, 32'(t[0]), 32'(RC[0] + 1));
        rst = 1'b1;
        step();
        rst       = 1'b0;
        cfg_valid = 1'b0;
        chk("gain_revert", 0, 32'(g[0]), 32'(DEFG[0]));
        repeat (10) step();

        repeat (2000) begin
            rst       = ($urandom_range(0, 96) == 0);
            cfg_valid = ($urandom_range(0, 5) == 0);
            cfg_data  = 12'($urandom);
            us        = 8'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
